// File: rtl/dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_responder: MEM-stage load/store responder driving a 64-bit req/ack bus.
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_wdata,
  output logic              mmu_data_ready,
  output logic [63:0]       mmu_rdata,
  output logic [1:0]        mmu_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic              bus_ack,
  input  logic [63:0]       bus_rdata
);

  // Counter holds the number of BUS cycles already spent, 0..TIMEOUT-1.
  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [63:0]       bus_wdata_q, bus_wdata_d;
  logic [7:0]        bus_wstrb_q, bus_wstrb_d;
  logic              ready_q, ready_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [1:0]        fault_q, fault_d;

  logic [2:0]        lane_mask;
  logic [7:0]        strb_base;
  logic [63:0]       data_mask;
  logic              req_bad;
  logic              timeout_hit;
  logic [63:0]       rd_shift;
  logic [63:0]       load_data;

  // Size decode of the incoming request; lane_mask flags address bits that must be zero.
  always_comb begin
    lane_mask = 3'b000;
    strb_base = 8'h01;
    data_mask = 64'h0000_0000_0000_00FF;
    case (mem_funct3[1:0])
      2'd0: begin lane_mask = 3'b000; strb_base = 8'h01; data_mask = 64'h0000_0000_0000_00FF; end
      2'd1: begin lane_mask = 3'b001; strb_base = 8'h03; data_mask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin lane_mask = 3'b011; strb_base = 8'h0F; data_mask = 64'h0000_0000_FFFF_FFFF; end
      2'd3: begin lane_mask = 3'b111; strb_base = 8'hFF; data_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
      default: ;
    endcase
    req_bad = ((mem_addr[2:0] & lane_mask) != 3'b000) || (mem_funct3 == 3'b111) ||
              (mem_funct3[2] && mem_we);
  end

  always_comb begin
    rd_shift = bus_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{56{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  load_data = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_data = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  load_data = {56'd0, rd_shift[7:0]};
      3'b101:  load_data = {48'd0, rd_shift[15:0]};
      3'b110:  load_data = {32'd0, rd_shift[31:0]};
      default: load_data = rd_shift;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_valid) state_d = req_bad ? S_DONE : S_BUS;
      S_BUS:   if (bus_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic feeding the registered outputs
  always_comb begin
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    ready_d     = 1'b0;
    rdata_d     = 64'd0;
    fault_d     = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          we_d     = mem_we;
          funct3_d = mem_funct3;
          lane_d   = mem_addr[2:0];
          cnt_d    = '0;
          if (req_bad) begin
            ready_d = 1'b1;
            fault_d = 2'b01;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we;
            bus_addr_d  = {mem_addr[ADDR_W-1:3], 3'b000};
            bus_wdata_d = mem_we ? ((mem_wdata & data_mask) << {mem_addr[2:0], 3'b000}) : 64'd0;
            bus_wstrb_d = mem_we ? (strb_base << mem_addr[2:0]) : 8'd0;
          end
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_ack || timeout_hit) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = 64'd0;
          bus_wstrb_d = 8'd0;
          ready_d     = 1'b1;
          // A same-cycle ack beats the timeout.
          if (bus_ack) rdata_d = we_q ? 64'd0 : load_data;
          else         fault_d = 2'b10;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 3'b000;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 64'd0;
      bus_wstrb_q <= 8'd0;
      ready_q     <= 1'b0;
      rdata_q     <= 64'd0;
      fault_q     <= 2'b00;
    end else begin
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  assign mmu_data_ready = ready_q;
  assign mmu_rdata      = rdata_q;
  assign mmu_fault      = fault_q;
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign bus_wstrb      = bus_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_responder: randomized and directed bench for dmem_responder.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_responder;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, mem_we;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic          mmu_data_ready;
  logic [63:0]   mmu_rdata;
  logic [1:0]    mmu_fault;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [63:0]   bus_wdata;
  logic [7:0]    bus_wstrb;
  logic          bus_ack;
  logic [63:0]   bus_rdata;

  int checks = 0;
  int failures = 0;

  dmem_responder #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mmu_data_ready(mmu_data_ready),
    .mmu_rdata(mmu_rdata), .mmu_fault(mmu_fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] rd;
    int          ack_at;
    int          e_ready;
    logic [1:0]  e_fault;
    logic [63:0] e_rdata;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
  } vec_t;

  // Byte-level reference: cycle numbers count edges after mem_valid is first sampled.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [63:0] wd, input logic [63:0] rd, input int ack_at,
                                output int e_ready, output logic [1:0] e_fault,
                                output logic [63:0] e_rdata, output logic [7:0] e_strb,
                                output logic [63:0] e_wdata, output int e_req_last);
    int n;
    int off;
    bit bad;
    bit acked;
    n     = 1 << f3[1:0];
    off   = int'(addr % 8);
    bad   = (f3 == 3'd7) || (we && f3 >= 3'd4) || ((addr % n) != 0);
    acked = (ack_at >= 1) && (ack_at <= TO);
    e_strb  = 8'd0;
    e_wdata = 64'd0;
    e_rdata = 64'd0;
    if (bad) begin
      e_ready = 1; e_fault = 2'd1; e_req_last = -1;
      return;
    end
    e_req_last = acked ? ack_at : TO;
    e_ready    = e_req_last + 1;
    e_fault    = acked ? 2'd0 : 2'd2;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        e_strb[off+i]        = 1'b1;
        e_wdata[8*(off+i)+:8] = wd[8*i+:8];
      end
    end else if (acked) begin
      for (int i = 0; i < n; i++) e_rdata[8*i+:8] = rd[8*(off+i)+:8];
      if (f3 < 3'd4 && n < 8 && e_rdata[8*n-1])
        for (int i = n; i < 8; i++) e_rdata[8*i+:8] = 8'hFF;
    end
  endfunction

  // Drives one request from IDLE and records what the DUT did; ends one cycle after ready.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd, input int ack_at,
                         input bit drop, output int r_cyc, output logic [1:0] o_fault,
                         output logic [63:0] o_rdata, output int rq_first, output int rq_last,
                         output logic [31:0] o_baddr, output logic o_bwe, output logic [7:0] o_strb,
                         output logic [63:0] o_bwd, output int unstable, output logic after_rdy);
    r_cyc = -1; rq_first = -1; rq_last = -1; unstable = 0;
    o_fault = 2'd0; o_rdata = 64'd0; o_baddr = '0; o_bwe = 1'b0; o_strb = 8'd0; o_bwd = 64'd0;
    mem_valid = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
    bus_ack = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = {$urandom, $urandom};
      if (drop) mem_valid = 1'b0;
      if (bus_req) begin
        if (rq_first < 0) begin
          rq_first = cyc; o_baddr = bus_addr; o_bwe = bus_we; o_strb = bus_wstrb; o_bwd = bus_wdata;
        end else if (bus_addr !== o_baddr || bus_we !== o_bwe || bus_wstrb !== o_strb ||
                     bus_wdata !== o_bwd) begin
          unstable++;
        end
        rq_last = cyc;
      end
      if (mmu_data_ready) begin
        r_cyc = cyc; o_fault = mmu_fault; o_rdata = mmu_rdata;
        break;
      end
      if (cyc == ack_at) begin
        bus_ack = 1'b1; bus_rdata = rd;
      end
    end
    mem_valid = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    after_rdy = mmu_data_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_valid = 1'b1; mem_we = 1'b0; mem_funct3 = 3'd3; mem_addr = 32'h100;
    mem_wdata = 64'd0; bus_ack = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mmu_data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", mmu_data_ready); end
    checks++; if (mmu_rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mmu_rdata); end
    checks++; if (mmu_fault !== 2'd0) begin failures++; $display("FAIL reset_fault got=%b exp=0", mmu_fault); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus_req); end
    checks++; if ({bus_we, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
      failures++; $display("FAIL reset_bus got we=%b addr=%h wd=%h strb=%h exp=0", bus_we, bus_addr, bus_wdata, bus_wstrb);
    end
    mem_valid = 1'b0; bus_ack = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_examples();
    vec_t v[14];
    int r, rf, rl, un;
    logic [1:0] f; logic [63:0] rdat, bwd; logic [31:0] ba; logic bwe, ar; logic [7:0] st;
    v[0]  = '{1'b0, 3'd3, 32'h100, 64'h0, 64'h1122334455667788, 3, 4, 2'd0, 64'h1122334455667788, 8'h00, 64'h0};
    v[1]  = '{1'b0, 3'd0, 32'h107, 64'h0, 64'h80AAAAAAAAAAAAAA, 1, 2, 2'd0, 64'hFFFFFFFFFFFFFF80, 8'h00, 64'h0};
    v[2]  = '{1'b0, 3'd4, 32'h107, 64'h0, 64'h80AAAAAAAAAAAAAA, 1, 2, 2'd0, 64'h0000000000000080, 8'h00, 64'h0};
    v[3]  = '{1'b0, 3'd5, 32'h106, 64'h0, 64'h80AAAAAAAAAAAAAA, 2, 3, 2'd0, 64'h00000000000080AA, 8'h00, 64'h0};
    v[4]  = '{1'b1, 3'd1, 32'h102, 64'h1234BEEF, 64'h5555, 2, 3, 2'd0, 64'h0, 8'h0C, 64'h00000000BEEF0000};
    v[5]  = '{1'b0, 3'd2, 32'h102, 64'h0, 64'h0, 1, 1, 2'd1, 64'h0, 8'h00, 64'h0};
    v[6]  = '{1'b0, 3'd7, 32'h100, 64'h0, 64'h0, 1, 1, 2'd1, 64'h0, 8'h00, 64'h0};
    v[7]  = '{1'b1, 3'd4, 32'h100, 64'h0, 64'h0, 1, 1, 2'd1, 64'h0, 8'h00, 64'h0};
    v[8]  = '{1'b1, 3'd3, 32'h108, 64'hDEADBEEFCAFEF00D, 64'h0, 1, 2, 2'd0, 64'h0, 8'hFF, 64'hDEADBEEFCAFEF00D};
    v[9]  = '{1'b0, 3'd1, 32'h104, 64'h0, 64'h0000800100000000, 1, 2, 2'd0, 64'hFFFFFFFFFFFF8001, 8'h00, 64'h0};
    v[10] = '{1'b0, 3'd6, 32'h104, 64'h0, 64'hF000000100000000, 4, 5, 2'd0, 64'h00000000F0000001, 8'h00, 64'h0};
    v[11] = '{1'b0, 3'd2, 32'h104, 64'h0, 64'hF000000100000000, 2, 3, 2'd0, 64'hFFFFFFFFF0000001, 8'h00, 64'h0};
    v[12] = '{1'b0, 3'd3, 32'h10C, 64'h0, 64'h0, 1, 1, 2'd1, 64'h0, 8'h00, 64'h0};
    v[13] = '{1'b1, 3'd0, 32'h105, 64'hFFFFFF5A, 64'h0, 1, 2, 2'd0, 64'h0, 8'h20, 64'h00005A0000000000};
    foreach (v[k]) begin
      run_txn(v[k].we, v[k].f3, v[k].addr, v[k].wd, v[k].rd, v[k].ack_at, 1'b0,
              r, f, rdat, rf, rl, ba, bwe, st, bwd, un, ar);
      checks++; if (r != v[k].e_ready || f !== v[k].e_fault || rdat !== v[k].e_rdata) begin
        failures++; $display("FAIL spec%0d_resp got cyc=%0d fault=%b rdata=%h exp cyc=%0d fault=%b rdata=%h",
                             k, r, f, rdat, v[k].e_ready, v[k].e_fault, v[k].e_rdata);
      end
      if (v[k].e_fault == 2'd1) begin
        checks++; if (rf != -1) begin failures++; $display("FAIL spec%0d_noreq got first_req=%0d exp=-1", k, rf); end
      end else begin
        checks++; if (rf != 1 || rl != v[k].ack_at || ba !== (v[k].addr & ~32'h7) || bwe !== v[k].we ||
                      st !== v[k].e_strb || (v[k].we && bwd !== v[k].e_wdata)) begin
          failures++; $display("FAIL spec%0d_bus got req=%0d..%0d addr=%h we=%b strb=%h wd=%h exp req=1..%0d addr=%h we=%b strb=%h wd=%h",
                               k, rf, rl, ba, bwe, st, bwd, v[k].ack_at, v[k].addr & ~32'h7, v[k].we, v[k].e_strb, v[k].e_wdata);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int r, rf, rl, un;
    logic [1:0] f; logic [63:0] rdat, bwd; logic [31:0] ba; logic bwe, ar; logic [7:0] st;
    run_txn(1'b0, 3'd3, 32'h300, 64'h0, 64'h0, -1, 1'b0, r, f, rdat, rf, rl, ba, bwe, st, bwd, un, ar);
    checks++; if (r != 5 || f !== 2'd2 || rdat !== 64'd0 || rf != 1 || rl != 4) begin
      failures++; $display("FAIL timeout_load got cyc=%0d fault=%b rdata=%h req=%0d..%0d exp cyc=5 fault=10 rdata=0 req=1..4", r, f, rdat, rf, rl);
    end
    run_txn(1'b1, 3'd2, 32'h304, 64'hAABBCCDD, 64'h0, -1, 1'b0, r, f, rdat, rf, rl, ba, bwe, st, bwd, un, ar);
    checks++; if (r != 5 || f !== 2'd2 || rdat !== 64'd0 || st !== 8'hF0) begin
      failures++; $display("FAIL timeout_store got cyc=%0d fault=%b rdata=%h strb=%h exp cyc=5 fault=10 rdata=0 strb=f0", r, f, rdat, st);
    end
    run_txn(1'b0, 3'd3, 32'h308, 64'h0, 64'h0123456789ABCDEF, 1, 1'b0, r, f, rdat, rf, rl, ba, bwe, st, bwd, un, ar);
    checks++; if (r != 2 || f !== 2'd0 || rdat !== 64'h0123456789ABCDEF) begin
      failures++; $display("FAIL timeout_recover got cyc=%0d fault=%b rdata=%h exp cyc=2 fault=00 rdata=0123456789abcdef", r, f, rdat);
    end
  endtask

  task automatic test_random(input int n);
    int r, rf, rl, un, er, erl, ack_at;
    logic [1:0] f, ef; logic [63:0] rdat, bwd, erd, ewd, wd, rd; logic [31:0] ba, addr;
    logic bwe, ar, we; logic [7:0] st, est; logic [2:0] f3; bit drop;
    for (int k = 0; k < n; k++) begin
      f3 = 3'($urandom_range(0, 7)); we = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      ack_at = $urandom_range(1, TO + 1); drop = ($urandom_range(0, 3) == 0);
      model(we, f3, addr, wd, rd, ack_at, er, ef, erd, est, ewd, erl);
      run_txn(we, f3, addr, wd, rd, ack_at, drop, r, f, rdat, rf, rl, ba, bwe, st, bwd, un, ar);
      checks++; if (r != er || f !== ef || rdat !== erd || ar !== 1'b0) begin
        failures++; $display("FAIL rand%0d_resp we=%b f3=%0d addr=%h ack=%0d got cyc=%0d fault=%b rdata=%h next_rdy=%b exp cyc=%0d fault=%b rdata=%h next_rdy=0",
                             k, we, f3, addr, ack_at, r, f, rdat, ar, er, ef, erd);
      end
      checks++; if (rl != erl || (erl > 0 && (rf != 1 || un != 0 || ba !== (addr & ~32'h7) || bwe !== we ||
                    st !== est || (we && bwd !== ewd)))) begin
        failures++; $display("FAIL rand%0d_bus we=%b f3=%0d addr=%h got req=%0d..%0d unstable=%0d addr=%h strb=%h wd=%h exp req_last=%0d strb=%h wd=%h",
                             k, we, f3, addr, rf, rl, un, ba, st, bwd, erl, est, ewd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rc[2];
    int nrdy;
    logic [63:0] got[2];
    logic [63:0] rda, rdb, e0, e1, dw;
    logic [7:0] ds;
    logic [1:0] df;
    int de, dl;
    rda = {$urandom, $urandom}; rdb = {$urandom, $urandom};
    model(1'b0, 3'd3, 32'h200, 64'd0, rda, 1, de, df, e0, ds, dw, dl);
    model(1'b0, 3'd4, 32'h20B, 64'd0, rdb, 1, de, df, e1, ds, dw, dl);
    nrdy = 0; rc[0] = -1; rc[1] = -1; got[0] = 64'd0; got[1] = 64'd0;
    mem_valid = 1'b1; mem_we = 1'b0; mem_funct3 = 3'd3; mem_addr = 32'h200; bus_ack = 1'b0;
    for (int cyc = 1; cyc <= 15 && nrdy < 2; cyc++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (mmu_data_ready) begin
        rc[nrdy] = cyc; got[nrdy] = mmu_rdata; nrdy++;
        mem_funct3 = 3'd4; mem_addr = 32'h20B;
        if (nrdy == 2) mem_valid = 1'b0;
      end
      if (bus_req) begin
        bus_ack = 1'b1; bus_rdata = (nrdy == 0) ? rda : rdb;
      end
    end
    mem_valid = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (rc[0] != 2 || rc[1] != 5) begin
      failures++; $display("FAIL b2b_timing got ready at %0d,%0d exp 2,5", rc[0], rc[1]);
    end
    checks++; if (got[0] !== e0 || got[1] !== e1) begin
      failures++; $display("FAIL b2b_data got %h,%h exp %h,%h", got[0], got[1], e0, e1);
    end
  endtask

  task automatic test_reset_mid();
    int r, rf, rl, un, seen;
    logic [1:0] f; logic [63:0] rdat, bwd; logic [31:0] ba; logic bwe, ar; logic [7:0] st;
    mem_valid = 1'b1; mem_we = 1'b0; mem_funct3 = 3'd3; mem_addr = 32'h400; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rstmid_req_before got=%b exp=1", bus_req); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0 || mmu_data_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got req=%b ready=%b exp 0,0", bus_req, mmu_data_ready);
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 64'hBAD0BAD0BAD0BAD0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (mmu_data_ready || bus_req) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_late_ack got activity_cycles=%0d exp=0", seen); end
    // bus_ack while idle must be ignored as well
    bus_ack = 1'b1; seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (mmu_data_ready || bus_req) seen++;
    end
    bus_ack = 1'b0;
    checks++; if (seen != 0) begin failures++; $display("FAIL idle_ack got activity_cycles=%0d exp=0", seen); end
    run_txn(1'b0, 3'd3, 32'h408, 64'h0, 64'h0F0E0D0C0B0A0908, 2, 1'b0, r, f, rdat, rf, rl, ba, bwe, st, bwd, un, ar);
    checks++; if (r != 3 || f !== 2'd0 || rdat !== 64'h0F0E0D0C0B0A0908 || ba !== 32'h408) begin
      failures++; $display("FAIL rstmid_after got cyc=%0d fault=%b rdata=%h addr=%h exp cyc=3 fault=00 rdata=0f0e0d0c0b0a0908 addr=408", r, f, rdat, ba);
    end
  endtask

  initial begin
    test_reset();
    test_spec_examples();
    test_timeout();
    test_random(80);
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
